alu_cc_unit: RTL and testbench
==============================

Name: alu_cc_unit

Overview:
- Datapath execute-stage block for the 16-bit LC-3-style core.
- Combinational ALU (8 ops) plus a combinational condition-code generator {n,z,p}.
- Holds the architectural CC register, updated from either the ALU result or an external value (memory load / IN port data).
- Feeds the branch-condition check and register-writeback paths.

Parameters:
- WIDTH, 16, datapath width in bits. Supported value is 16 only; other values are not required.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  3  ALU operation (op_t from package)
- a  input  WIDTH  first operand (register, PC, or 0)
- b  input  WIDTH  second operand (register or immediate)
- result  output  WIDTH  ALU result, combinational
- cc  output  3  {n,z,p} of result, combinational
- value  input  WIDTH  external value (load data / IN data)
- value_cc  output  3  {n,z,p} of value, combinational
- cc_we  input  1  update CC register this cycle
- cc_sel  input  1  CC register source: 0 = cc (ALU), 1 = value_cc
- cc_q  output  3  architectural CC register

Behaviour:
- op encoding: ADD=0, AND=1, XOR=2, OR=3, SUB=4, LSL=5, LSR=6, MUL=7.
- ADD: (a+b) mod 2^16; carry discarded.
- SUB: (a-b) mod 2^16; borrow discarded.
- AND, OR, XOR: bitwise.
- MUL: low 16 bits of the unsigned product a*b. The low 16 bits are the same for signed operands.
- LSL: a << b. If b >= 16 (any bit of b[15:4] set), result = 0.
- LSR: logical a >> b, zero fill. If b >= 16, result = 0.
- result and cc are purely combinational from op/a/b, with zero-cycle latency; the same applies to value → value_cc. Neither depends on clock or reset.
- CC function for value v:
  - v[15]=1 → 3'b100
  - else v==0 → 3'b010
  - else → 3'b001
  - Exactly one bit is always set.
- CC register:
  - reset=1 at a rising edge → cc_q = 3'b111. This allows any branch condition after reset.
  - Else if cc_we=1 → cc_q <= (cc_sel ? value_cc : cc).
  - Else cc_q holds.
  - Reset has priority over cc_we.
  - cc_q is valid one cycle after the update edge, with no bypass. The consumer sees the old cc_q during the writing cycle.
- No X propagation allowed on result for defined inputs; all ops are fully specified.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] op_t {ADD, AND, XOR, OR, SUB, LSL, LSR, MUL} with the encodings above.
  - Constant CC_RESET = 3'b111.
  - CC bit-index constants N=2, Z=1, P=0.
- Sub-module cc_gen (value[WIDTH] → cc[3]), pure combinational. It is instantiated twice: once on result, once on value.
- ALU op mux inline in alu_cc_unit.

Test Plan:
- Reset asserted one cycle, cc_we=0 → cc_q=3'b111. Then cc_we=1, cc_sel=0, ADD a=5 b=-5 → result=0, cc=010, cc_q=010 next cycle.
- ADD a=16'h7FFF b=1 → result=16'h8000, cc=100. SUB a=3 b=5 → 16'hFFFE, cc=100. SUB a=5 b=3 → 2, cc=001.
- AND 16'hF0F0 & 16'h0FF0 → 16'h00F0. OR → 16'hFFF0. XOR → 16'hFF00, cc=100.
- LSL a=1 b=15 → 16'h8000; LSL a=1 b=16 → 0 (cc=010). LSR a=16'h8000 b=15 → 1; LSR b=20 → 0.
- MUL a=300 b=300 → 16'h5F90 (90000 mod 65536). MUL a=16'hFFFF b=16'hFFFF → 1.
- cc_sel=1, value=16'h8001, cc_we=1 → value_cc=100, cc_q=100 next cycle. Hold with cc_we=0 for 3 cycles → stays 100. reset and cc_we both high → 111.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU and condition-code logic.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        AND = 3'd1,
        XOR = 3'd2,
        OR  = 3'd3,
        SUB = 3'd4,
        LSL = 3'd5,
        LSR = 3'd6,
        MUL = 3'd7
    } op_t;

    localparam logic [2:0] CC_RESET = 3'b111;

    // Bit positions within an {n,z,p} condition-code vector
    localparam int N = 2;
    localparam int Z = 1;
    localparam int P = 0;

endpackage

// File: rtl/alu_cc_unit_if.sv
// Operand, result and condition-code bundle between the execute control and alu_cc_unit.
interface alu_cc_unit_if #(
    parameter int WIDTH = 16
);
    import alu_pkg::*;

    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [2:0]       cc;
    logic [WIDTH-1:0] value;
    logic [2:0]       value_cc;
    logic             cc_we;
    logic             cc_sel;
    logic [2:0]       cc_q;

    modport master (
        output op, a, b, value, cc_we, cc_sel,
        input  result, cc, value_cc, cc_q
    );

    modport slave (
        input  op, a, b, value, cc_we, cc_sel,
        output result, cc, value_cc, cc_q
    );

endinterface

// File: rtl/cc_gen.sv
// {n,z,p} classifier of a two's-complement value; combinational, exactly one bit set.
module cc_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    output logic [2:0]       cc
);

    always_comb begin
        cc = '0;
        if (value[WIDTH-1])
            cc[N] = 1'b1;
        else if (value == '0)
            cc[Z] = 1'b1;
        else
            cc[P] = 1'b1;
    end

endmodule

// File: rtl/alu_cc_unit.sv
// Execute stage: zero-latency ALU with {n,z,p} of result and external value, plus the CC register.
// cc_q updates one cycle after a cc_we edge with no bypass; no flow control.
module alu_cc_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    alu_cc_unit_if.slave  bus
);

    // Any set bit above the low nibble means a shift distance of 16 or more
    logic shift_overflow;
    assign shift_overflow = |bus.b[WIDTH-1:4];

    always_comb begin
        bus.result = '0;
        case (bus.op)
            ADD: bus.result = bus.a + bus.b;
            AND: bus.result = bus.a & bus.b;
            XOR: bus.result = bus.a ^ bus.b;
            OR:  bus.result = bus.a | bus.b;
            SUB: bus.result = bus.a - bus.b;
            LSL: bus.result = shift_overflow ? '0 : (bus.a << bus.b[3:0]);
            LSR: bus.result = shift_overflow ? '0 : (bus.a >> bus.b[3:0]);
            MUL: bus.result = bus.a * bus.b;
            default: bus.result = '0;
        endcase
    end

    cc_gen #(.WIDTH(WIDTH)) u_result_cc (
        .value (bus.result),
        .cc    (bus.cc)
    );

    cc_gen #(.WIDTH(WIDTH)) u_value_cc (
        .value (bus.value),
        .cc    (bus.value_cc)
    );

    always_ff @(posedge clock) begin
        if (reset)
            bus.cc_q <= CC_RESET;
        else if (bus.cc_we)
            bus.cc_q <= bus.cc_sel ? bus.value_cc : bus.cc;
    end

endmodule

// File: tb/tb_alu_cc_unit.sv
// Directed-vector bench for alu_cc_unit: ALU ops, CC generation and CC register behaviour.
module tb_alu_cc_unit;
    import alu_pkg::*;

    typedef struct {
        op_t         op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [2:0]  c;
    } vec_t;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    alu_cc_unit_if #(.WIDTH(16)) bus ();

    alu_cc_unit #(.WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        @(negedge clock);
        reset      = 1'b1;
        bus.cc_we  = 1'b0;
        bus.cc_sel = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if (bus.cc_q !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_cc_q: got %b expected %b", bus.cc_q, 3'b111);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_add_zero();
        @(negedge clock);
        bus.op = ADD; bus.a = 16'd5; bus.b = 16'hFFFB;
        bus.cc_we = 1'b1; bus.cc_sel = 1'b0;
        #1;
        vectors++;
        if (bus.result !== 16'h0000) begin
            miscompares++;
            $display("FAIL add_zero_result: got %h expected %h", bus.result, 16'h0000);
        end
        vectors++;
        if (bus.cc !== 3'b010) begin
            miscompares++;
            $display("FAIL add_zero_cc: got %b expected %b", bus.cc, 3'b010);
        end
        vectors++;
        if (bus.cc_q !== 3'b111) begin
            miscompares++;
            $display("FAIL cc_q_no_bypass: got %b expected %b", bus.cc_q, 3'b111);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (bus.cc_q !== 3'b010) begin
            miscompares++;
            $display("FAIL add_zero_cc_q: got %b expected %b", bus.cc_q, 3'b010);
        end
        @(negedge clock);
        bus.cc_we = 1'b0;
    endtask

    task automatic test_ops();
        vec_t v[19];
        v = '{
            '{ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b100},
            '{ADD, 16'hFFFF, 16'h0002, 16'h0001, 3'b001},
            '{SUB, 16'h0003, 16'h0005, 16'hFFFE, 3'b100},
            '{SUB, 16'h0005, 16'h0003, 16'h0002, 3'b001},
            '{SUB, 16'h1234, 16'h1234, 16'h0000, 3'b010},
            '{AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b001},
            '{OR,  16'hF0F0, 16'h0FF0, 16'hFFF0, 3'b100},
            '{XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 3'b100},
            '{LSL, 16'h0001, 16'd15,   16'h8000, 3'b100},
            '{LSL, 16'h0001, 16'd16,   16'h0000, 3'b010},
            '{LSL, 16'h0003, 16'd4,    16'h0030, 3'b001},
            '{LSL, 16'h0001, 16'h0100, 16'h0000, 3'b010},
            '{LSR, 16'h8000, 16'd15,   16'h0001, 3'b001},
            '{LSR, 16'h8000, 16'd20,   16'h0000, 3'b010},
            '{LSR, 16'hFFFF, 16'd4,    16'h0FFF, 3'b001},
            '{MUL, 16'd300,  16'd300,  16'h5F90, 3'b001},
            '{MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b001},
            '{MUL, 16'h0100, 16'h0100, 16'h0000, 3'b010},
            '{MUL, 16'h0002, 16'h4000, 16'h8000, 3'b100}
        };
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            bus.op = v[i].op; bus.a = v[i].a; bus.b = v[i].b;
            #1;
            vectors++;
            if (bus.result !== v[i].r) begin
                miscompares++;
                $display("FAIL op_result[%0d] %s a=%h b=%h: got %h expected %h",
                         i, v[i].op.name(), v[i].a, v[i].b, bus.result, v[i].r);
            end
            vectors++;
            if (bus.cc !== v[i].c) begin
                miscompares++;
                $display("FAIL op_cc[%0d] %s: got %b expected %b",
                         i, v[i].op.name(), bus.cc, v[i].c);
            end
        end
    endtask

    task automatic test_value_cc();
        logic [15:0] vals[3];
        logic [2:0]  exp[3];
        vals = '{16'h8001, 16'h0000, 16'h0001};
        exp  = '{3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.cc_we = 1'b0;
            bus.value = vals[i];
            #1;
            vectors++;
            if (bus.value_cc !== exp[i]) begin
                miscompares++;
                $display("FAIL value_cc[%0d] value=%h: got %b expected %b",
                         i, vals[i], bus.value_cc, exp[i]);
            end
        end
    endtask

    task automatic test_cc_sel_and_hold();
        // ALU cc is 010 here so a wrong source select is visible
        @(negedge clock);
        bus.op = ADD; bus.a = 16'h0000; bus.b = 16'h0000;
        bus.value = 16'h8001; bus.cc_sel = 1'b1; bus.cc_we = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if (bus.cc_q !== 3'b100) begin
            miscompares++;
            $display("FAIL cc_sel_value: got %b expected %b", bus.cc_q, 3'b100);
        end
        @(negedge clock);
        bus.cc_we = 1'b0;
        bus.value = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            vectors++;
            if (bus.cc_q !== 3'b100) begin
                miscompares++;
                $display("FAIL cc_hold[%0d]: got %b expected %b", i, bus.cc_q, 3'b100);
            end
        end
        // ALU source while value would give a different code
        @(negedge clock);
        bus.op = ADD; bus.a = 16'h0002; bus.b = 16'h0003;
        bus.value = 16'h0000; bus.cc_sel = 1'b0; bus.cc_we = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if (bus.cc_q !== 3'b001) begin
            miscompares++;
            $display("FAIL cc_sel_alu: got %b expected %b", bus.cc_q, 3'b001);
        end
        @(negedge clock);
        bus.cc_we = 1'b0;
    endtask

    task automatic test_reset_priority();
        @(negedge clock);
        bus.op = ADD; bus.a = 16'h0000; bus.b = 16'h0000;
        bus.cc_sel = 1'b0; bus.cc_we = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if (bus.cc_q !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_over_we: got %b expected %b", bus.cc_q, 3'b111);
        end
        @(negedge clock);
        reset = 1'b0;
        bus.cc_we = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.op      = ADD;
        bus.a       = '0;
        bus.b       = '0;
        bus.value   = '0;
        bus.cc_we   = 1'b0;
        bus.cc_sel  = 1'b0;
        repeat (2) @(posedge clock);

        test_reset();
        test_add_zero();
        test_ops();
        test_value_cc();
        test_cc_sel_and_hold();
        test_reset_priority();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
